// File: rtl/uart_rx_buf.sv
// uart_rx_buf: 8N1 UART receiver feeding a first-word-fall-through byte FIFO.
// Bytes arriving while the consumer is not ready stay in the FIFO. The overrun
// and frame_err flags are sticky and clear only on reset.
module uart_rx_buf #(
  parameter int CLK_PER_BIT = 868,
  parameter int DEPTH_LOG2  = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  rxd,
  output logic [7:0]            io_in_data,
  output logic                  io_in_vld,
  input  logic                  io_in_rdy,
  output logic [DEPTH_LOG2:0]   rx_count,
  output logic                  overrun,
  output logic                  frame_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = $clog2(CLK_PER_BIT);

  localparam logic [CW-1:0]         HALF_RELOAD = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]         BIT_RELOAD  = CW'(CLK_PER_BIT - 1);
  localparam logic [DEPTH_LOG2:0]   FULL_COUNT  = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE     = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE     = (DEPTH_LOG2 + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } rx_state_t;

  rx_state_t             state;
  logic                  rx_meta;
  logic                  rxs;
  logic [CW-1:0]         cnt;
  logic [2:0]            idx;
  logic [7:0]            sh;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;

  logic                  bit_done;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  accept;

  assign bit_done = (cnt == '0);
  // A complete byte is offered to the FIFO on the edge its stop bit samples high.
  assign push     = (state == S_STOP) && bit_done && rxs;
  assign io_in_vld  = (rx_count != '0);
  assign io_in_data = io_in_vld ? mem[rd_ptr] : 8'h00;
  assign pop      = io_in_vld && io_in_rdy;
  assign full     = (rx_count == FULL_COUNT);
  // A full FIFO still accepts a byte when a pop frees a slot on the same edge.
  assign accept   = push && (!full || pop);

  // Two-flop synchronizer; the line idles high, so both flops reset to 1.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  // Receiver FSM: mid-bit sampling of start, eight data bits LSB first, stop.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= S_IDLE;
      cnt       <= '0;
      idx       <= 3'd0;
      sh        <= 8'h00;
      frame_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!rxs) begin
            state <= S_START;
            cnt   <= HALF_RELOAD;
          end
        end
        S_START: begin
          if (!bit_done) begin
            cnt <= cnt - CW'(1);
          end else if (!rxs) begin
            state <= S_DATA;
            cnt   <= BIT_RELOAD;
            idx   <= 3'd0;
          end else begin
            state <= S_IDLE;
          end
        end
        S_DATA: begin
          if (!bit_done) begin
            cnt <= cnt - CW'(1);
          end else begin
            sh  <= {rxs, sh[7:1]};
            cnt <= BIT_RELOAD;
            if (idx == 3'd7) begin
              state <= S_STOP;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
        S_STOP: begin
          if (!bit_done) begin
            cnt <= cnt - CW'(1);
          end else if (rxs) begin
            state <= S_IDLE;
          end else begin
            frame_err <= 1'b1;
            state     <= S_BREAK;
          end
        end
        S_BREAK: begin
          if (rxs) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // FIFO bookkeeping: pointers, occupancy and the sticky overrun flag.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rx_count <= '0;
      overrun  <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (accept && !pop) begin
        rx_count <= rx_count + CNT_ONE;
      end else if (pop && !accept) begin
        rx_count <= rx_count - CNT_ONE;
      end
      if (push && !accept) begin
        overrun <= 1'b1;
      end
    end
  end

  // FIFO storage; contents need no reset because io_in_data is masked when empty.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= sh;
    end
  end

endmodule

// File: tb/tb_uart_rx_buf.sv
// tb_uart_rx_buf: directed and randomized frames against a queue-based model
// of the receiver and its FIFO, checked every cycle plus literal checkpoints.
module tb_uart_rx_buf;

  localparam int CPB   = 8;
  localparam int DL2   = 2;
  localparam int DEPTH = 1 << DL2;

  logic           clk;
  logic           rstn;
  logic           rxd;
  logic [7:0]     io_in_data;
  logic           io_in_vld;
  logic           io_in_rdy;
  logic [DL2:0]   rx_count;
  logic           overrun;
  logic           frame_err;

  uart_rx_buf #(.CLK_PER_BIT(CPB), .DEPTH_LOG2(DL2)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .rxd        (rxd),
    .io_in_data (io_in_data),
    .io_in_vld  (io_in_vld),
    .io_in_rdy  (io_in_rdy),
    .rx_count   (rx_count),
    .overrun    (overrun),
    .frame_err  (frame_err)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scheduled frame outcome: the edge where the stop bit is judged, the byte,
  // and whether the stop bit is good. Written only by the stimulus.
  int         ev_cycle = -1;
  int         ev_start = 0;
  logic [7:0] ev_byte  = 8'h00;
  bit         ev_good  = 1'b0;

  // Model state, written only by the model process.
  int         cyc      = 0;
  int         last_rst = -1;
  logic [7:0] q[$];
  bit         m_over   = 1'b0;
  bit         m_ferr   = 1'b0;
  bit         m_hit;
  bit         m_pop;
  bit         m_full;

  int  total  = 0;
  int  bad    = 0;
  bit  chk_en = 1'b0;

  // Behavioural model: a frame started after edge E0 is judged on edge
  // E0 + 3 + CPB/2 + 9*CPB (2 sync flops, 1 idle detect, half bit, 9 bits).
  always @(posedge clk) begin
    if (!rstn) begin
      q.delete();
      m_over   = 1'b0;
      m_ferr   = 1'b0;
      last_rst = cyc;
    end else begin
      m_hit  = (cyc == ev_cycle) && (ev_start > last_rst);
      m_pop  = (q.size() != 0) && io_in_rdy;
      m_full = (q.size() == DEPTH);
      if (m_pop) void'(q.pop_front());
      if (m_hit && ev_good) begin
        if (!m_full || m_pop) q.push_back(ev_byte);
        else m_over = 1'b1;
      end
      if (m_hit && !ev_good) m_ferr = 1'b1;
    end
    cyc = cyc + 1;
  end

  task automatic cmpVal(input string name, input int act, input int exp);
    total = total + 1;
    if (act != exp) begin
      bad = bad + 1;
      $display("[TB] FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Every-cycle comparison of the DUT against the model.
  task automatic compareLoop();
    forever begin
      @(negedge clk);
      if (chk_en) begin
        cmpVal("vld",       int'(io_in_vld),  int'(q.size() != 0));
        cmpVal("data",      int'(io_in_data), (q.size() != 0) ? int'(q[0]) : 0);
        cmpVal("rx_count",  int'(rx_count),   q.size());
        cmpVal("overrun",   int'(overrun),    int'(m_over));
        cmpVal("frame_err", int'(frame_err),  int'(m_ferr));
      end
    end
  endtask

  task automatic checkOutput(input string tag, input bit e_vld, input logic [7:0] e_data,
                             input int e_cnt, input bit e_over, input bit e_ferr);
    cmpVal({tag, ".vld"},       int'(io_in_vld),  int'(e_vld));
    cmpVal({tag, ".data"},      int'(io_in_data), int'(e_data));
    cmpVal({tag, ".rx_count"},  int'(rx_count),   e_cnt);
    cmpVal({tag, ".overrun"},   int'(overrun),    int'(e_over));
    cmpVal({tag, ".frame_err"}, int'(frame_err),  int'(e_ferr));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit rand_rdy);
    for (int k = 0; k < n; k++) begin
      step();
      if (rand_rdy) io_in_rdy = ($urandom_range(0, 2) == 0);
    end
  endtask

  task automatic applyReset();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
  endtask

  task automatic popOne();
    io_in_rdy = 1'b1;
    step();
    io_in_rdy = 1'b0;
  endtask

  // Drives one frame starting now (just after an edge). abort_bit >= 0 pulses
  // reset at the start of that bit and releases the line high.
  task automatic applyStimulus(input logic [7:0] b, input bit stop_ok, input bit rdy_on_push,
                               input int abort_bit, input bit rand_rdy);
    logic [9:0] bits;
    bits     = {stop_ok, b, 1'b0};
    ev_byte  = b;
    ev_good  = stop_ok;
    ev_start = cyc;
    ev_cycle = cyc + 2 + CPB / 2 + 9 * CPB;
    for (int n = 0; n < 10; n++) begin
      if (n == abort_bit) begin
        rxd = 1'b1;
        applyReset();
        return;
      end
      rxd = bits[n];
      for (int k = 1; k <= CPB; k++) begin
        step();
        if (rand_rdy) io_in_rdy = ($urandom_range(0, 2) == 0);
        if (n == 9 && rdy_on_push && k == CPB / 2 + 2) io_in_rdy = 1'b1;
        if (n == 9 && rdy_on_push && k == CPB / 2 + 3) io_in_rdy = 1'b0;
      end
    end
  endtask

  initial begin
    rstn      = 1'b0;
    rxd       = 1'b1;
    io_in_rdy = 1'b0;
    fork
      compareLoop();
    join_none
    step();
    step();
    rstn   = 1'b1;
    chk_en = 1'b1;
    checkOutput("reset", 1'b0, 8'h00, 0, 1'b0, 1'b0);

    // Idle line with the consumer ready.
    io_in_rdy = 1'b1;
    idle(200, 1'b0);
    io_in_rdy = 1'b0;
    checkOutput("idle", 1'b0, 8'h00, 0, 1'b0, 1'b0);

    // Single byte, then one pop.
    applyStimulus(8'hA5, 1'b1, 1'b0, -1, 1'b0);
    checkOutput("a5", 1'b1, 8'hA5, 1, 1'b0, 1'b0);
    popOne();
    checkOutput("a5_pop", 1'b0, 8'h00, 0, 1'b0, 1'b0);

    // Overflow: the fifth byte is dropped.
    for (int i = 1; i <= 5; i++) applyStimulus(8'(i), 1'b1, 1'b0, -1, 1'b0);
    checkOutput("ovf", 1'b1, 8'h01, 4, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      checkOutput("ovf_pop", 1'b1, 8'(i), 5 - i, 1'b1, 1'b0);
      popOne();
    end
    checkOutput("ovf_empty", 1'b0, 8'h00, 0, 1'b1, 1'b0);

    // Full FIFO with a pop on the push edge keeps every byte.
    applyReset();
    for (int i = 1; i <= 4; i++) applyStimulus(8'(8'h10 + i), 1'b1, 1'b0, -1, 1'b0);
    applyStimulus(8'h15, 1'b1, 1'b1, -1, 1'b0);
    checkOutput("full_pp", 1'b1, 8'h12, 4, 1'b0, 1'b0);
    for (int i = 2; i <= 5; i++) begin
      checkOutput("full_pp_pop", 1'b1, 8'(8'h10 + i), 6 - i, 1'b0, 1'b0);
      popOne();
    end

    // Bad stop bit, line held low, then a clean frame.
    applyStimulus(8'h77, 1'b0, 1'b0, -1, 1'b0);
    idle(40, 1'b0);
    rxd = 1'b1;
    idle(2 * CPB, 1'b0);
    checkOutput("break", 1'b0, 8'h00, 0, 1'b0, 1'b1);
    applyStimulus(8'h3C, 1'b1, 1'b0, -1, 1'b0);
    checkOutput("after_break", 1'b1, 8'h3C, 1, 1'b0, 1'b1);
    popOne();

    // Short glitch, then reset in the middle of a frame.
    applyReset();
    rxd = 1'b0;
    idle(2, 1'b0);
    rxd = 1'b1;
    idle(3 * CPB, 1'b0);
    checkOutput("glitch", 1'b0, 8'h00, 0, 1'b0, 1'b0);
    applyStimulus(8'h5A, 1'b1, 1'b0, 3, 1'b0);
    idle(12 * CPB, 1'b0);
    checkOutput("mid_rst", 1'b0, 8'h00, 0, 1'b0, 1'b0);
    applyStimulus(8'hC3, 1'b1, 1'b0, -1, 1'b0);
    checkOutput("post_rst", 1'b1, 8'hC3, 1, 1'b0, 1'b0);
    popOne();

    // Random traffic with a randomly ready consumer.
    for (int i = 0; i < 30; i++) begin
      applyStimulus(8'($urandom_range(0, 255)), 1'b1, 1'b0, -1, 1'b1);
      idle($urandom_range(0, 20), 1'b1);
    end
    io_in_rdy = 1'b1;
    idle(10, 1'b0);
    io_in_rdy = 1'b0;
    cmpVal("drain.vld", int'(io_in_vld), 0);
    cmpVal("drain.rx_count", int'(rx_count), 0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_buf.md
Name: uart_rx_buf

Overview:
- Receive-side I/O front end for the memory/IO execution unit.
- Deserializes 8N1 UART frames from the rxd pin and buffers the received bytes in a FIFO.
- Presents the bytes on the unit's byte-input handshake (io_in_data / io_in_vld / io_in_rdy).
- Decouples line timing from the core, so bytes arriving while no IN instruction is pending are not lost.

Parameters:
- CLK_PER_BIT, 868: clk cycles per UART bit (100 MHz / 115200); must be >= 4.
- DEPTH_LOG2, 4: FIFO depth is 2**DEPTH_LOG2 bytes.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- rxd  in  1  asynchronous serial line, idle high
- io_in_data  out  8  FIFO head byte, valid while io_in_vld=1
- io_in_vld  out  1  FIFO non-empty
- io_in_rdy  in  1  consumer ready; a byte transfers on every clk edge where io_in_vld&&io_in_rdy
- rx_count  out  DEPTH_LOG2+1  bytes currently buffered
- overrun  out  1  sticky: a complete byte was dropped because the FIFO was full
- frame_err  out  1  sticky: a stop bit sampled low

Behaviour:
- Reset (rstn=0 at a clk edge):
  - FIFO emptied; io_in_vld=0, io_in_data=0, rx_count=0, overrun=0, frame_err=0.
  - Receiver goes to IDLE; both rxd synchronizer flops are set to 1.
  - Reset mid-frame abandons the partial byte; no push occurs.
- Synchronizer: rxd passes through 2 flops; rxs is the second flop. All receiver decisions use rxs only.
- Receiver FSM, with bit counter cnt, bit index idx (0-7) and shift register sh:
  - IDLE: if rxs==0, go to START with cnt=CLK_PER_BIT/2-1.
  - START: cnt decrements each cycle. At cnt==0:
    - rxs==0: go to DATA, cnt=CLK_PER_BIT-1, idx=0.
    - rxs==1: glitch; go to IDLE, nothing recorded.
  - DATA: at cnt==0, sh={rxs,sh[7:1]} (LSB first) and cnt reloads CLK_PER_BIT-1. When idx==7 go to STOP, else idx+1.
  - STOP: at cnt==0:
    - rxs==1: push sh, go to IDLE.
    - rxs==0: frame_err<=1, byte discarded, go to BREAK.
  - BREAK: stay until rxs==1, then go to IDLE. This prevents a held-low line from producing spurious frames.
- FIFO: circular buffer with DEPTH_LOG2-bit read and write pointers that wrap modulo depth. Occupancy is held in rx_count.
  - io_in_vld = (rx_count != 0). io_in_data = mem[rd_ptr], first-word fall-through.
  - A pushed byte is visible on io_in_data with io_in_vld=1 from the cycle after the push edge.
  - Pop: on an edge with io_in_vld&&io_in_rdy, rd_ptr+1 and rx_count-1. io_in_rdy while empty has no effect.
  - Push while not full: write at wr_ptr, wr_ptr+1, rx_count+1.
  - Push while full, no pop that edge: byte dropped, overrun<=1, pointers unchanged.
  - Push while full with a pop the same edge: push accepted, rx_count stays at depth, overrun unchanged.
  - Push and pop same edge, not empty: both occur, rx_count unchanged.
  - Push into empty FIFO: the pop logic sees io_in_vld=0 that edge, so no pop.
- Consumer compatibility: the consumer holds io_in_rdy high until it sees io_in_vld, captures on the same edge, then drops rdy. Exactly one byte is popped per IN, provided rdy is high for only one vld-qualified edge.
- overrun and frame_err clear only on reset.

Test Plan (CLK_PER_BIT=8, DEPTH_LOG2=2):
- Idle line, io_in_rdy=1 for 200 cycles -> io_in_vld=0, rx_count=0, no pops, flags 0.
- Send 0xA5 (8N1), io_in_rdy=0 -> after stop sample io_in_vld=1, io_in_data=0xA5, rx_count=1. Raise io_in_rdy for one cycle -> io_in_vld=0 next cycle, rx_count=0.
- Send 0x01,0x02,0x03,0x04,0x05 with no pops -> rx_count=4, overrun=1. Popping 4 times yields 0x01..0x04 in order; 0x05 is lost.
- Fill to 4 bytes, assert io_in_rdy exactly on the 5th byte's push edge -> rx_count stays 4, overrun=0. Subsequent pops yield bytes 2..5.
- Send a frame with stop bit 0, then hold rxd low 40 cycles, then high, then send 0x3C -> frame_err=1, the bad byte is not pushed, no frame from the held-low period, and 0x3C is received correctly.
- Apply a 2-cycle low pulse on the idle line -> START rejects it as a glitch: no push, frame_err=0. Also assert rstn=0 mid-DATA -> after reset rx_count=0, no partial byte is delivered, and the next frame is received correctly.
